// File: rtl/seven_segment_capture.sv
// Seven-segment bus reader: debounces each scanned (segments, digit-select) pair,
// decodes it back to a nibble and publishes a complete scan as one frame.
module seven_segment_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  clr_err,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  frame_valid,
  output logic                  seg_err,
  output logic [2:0]            err_digit
);

  localparam logic [3:0]        STAB = 4'(STABLE);
  localparam logic [DIGITS-1:0] ONE  = DIGITS'(1);

  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   dig_q;
  logic [3:0]          stab_cnt;
  logic [3:0]          cnt_next;
  logic                hit;
  logic                hit_next;
  logic [DIGITS-1:0]   mask;
  logic [4*DIGITS-1:0] shadow;
  logic                mask_full;
  logic                one_hot;
  logic                commit;
  logic [2:0]          idx;
  logic [3:0]          dec;
  logic                bad;

  // A run commits once: hit fires only on the edge where the counter first saturates.
  always_comb begin
    cnt_next = 4'd1;
    if ((seg_in == seg_q) && (dig_sel == dig_q)) begin
      cnt_next = (stab_cnt == STAB) ? stab_cnt : stab_cnt + 4'd1;
    end
    hit_next  = (cnt_next == STAB) && (stab_cnt != STAB);
    one_hot   = (dig_q != '0) && ((dig_q & (dig_q - ONE)) == '0);
    commit    = hit && one_hot;
    mask_full = &mask;
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[i]) idx = 3'(i);
    end
  end

  always_comb begin
    dec = 4'hE;
    case (seg_q)
      7'b1111110: dec = 4'h0;
      7'b0110000: dec = 4'h1;
      7'b1101101: dec = 4'h2;
      7'b1111001: dec = 4'h3;
      7'b0110011: dec = 4'h4;
      7'b1011011: dec = 4'h5;
      7'b1011111: dec = 4'h6;
      7'b1110000: dec = 4'h7;
      7'b1111111: dec = 4'h8;
      7'b1111011: dec = 4'h9;
      7'b0000000: dec = 4'hF;
      default:    dec = 4'hE;
    endcase
    bad = (dec == 4'hE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '0;
      dig_q       <= '0;
      stab_cnt    <= '0;
      hit         <= 1'b0;
      mask        <= '0;
      shadow      <= '1;
      digits_out  <= '1;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      err_digit   <= '0;
    end else begin
      seg_q       <= seg_in;
      dig_q       <= dig_sel;
      stab_cnt    <= cnt_next;
      hit         <= hit_next;
      frame_valid <= mask_full;
      if (mask_full) digits_out <= shadow;

      // A commit coinciding with the frame hand-off seeds the next frame's mask.
      if (mask_full) mask <= commit ? dig_q : '0;
      else if (commit) mask <= mask | dig_q;

      for (int i = 0; i < DIGITS; i++) begin
        if (commit && dig_q[i]) shadow[4*i +: 4] <= dec;
      end

      if (commit && bad) begin
        seg_err   <= 1'b1;
        err_digit <= idx;
      end else if (clr_err) begin
        seg_err   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Reader for the multiplexed seven-segment display bus; the inverse of the seven_segment encoder.
- Watches the scanned segment lines (ABCDEFG, active-high, bit6=A … bit0=G) and the one-hot digit select.
- Waits for each pattern to be stable, decodes it back to a 4-bit value and collects a complete scan into a frame.
- Used as a loopback checker and display-readback monitor next to the display driver.

Parameters:
DIGITS, 4, number of scanned digit positions (1..8)
STABLE, 3, number of consecutive identical samples required before a commit (2..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
seg_in  input  7  segment lines ABCDEFG, bit6=A, bit0=G, 1=lit
dig_sel  input  DIGITS  digit select, one-hot, bit i = digit i
clr_err  input  1  clears seg_err
digits_out  output  4*DIGITS  last complete frame; digit i at [4i+3:4i]
frame_valid  output  1  one-cycle pulse when digits_out is updated
seg_err  output  1  sticky flag: an undecodable pattern was committed
err_digit  output  3  digit index of the most recent undecodable commit

Behaviour:
- Reset values:
  - digits_out = all 4'hF; frame_valid = 0; seg_err = 0; err_digit = 0.
  - Internally: sample registers, stability counter, capture mask and shadow all cleared. Shadow resets to 4'hF.
  - Reset mid-frame discards the partial frame.
- Stage 1 (sample):
  - seg_in and dig_sel are registered every edge.
  - The pair is compared with the previously registered pair.
  - Equal: stab_cnt increments, saturating at STABLE. Different: stab_cnt = 1.
- Commit:
  - Occurs on the edge after stab_cnt first reaches STABLE.
  - Exactly once per stable run; saturation prevents repeats.
  - Commit is suppressed when the registered dig_sel is not one-hot (zero or multiple bits set). Nothing is written and there is no error.
- Decode table:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000→4'hF (blank, legal).
  - Any other pattern is written as 4'hE, sets seg_err and loads err_digit with the index.
- Commit action:
  - shadow[i] ← decoded value and mask[i] ← 1.
  - Re-commit of an already captured digit overwrites shadow[i] without any other effect.
- Frame completion:
  - On the edge after mask becomes all ones: digits_out ← shadow (all digits at once), frame_valid = 1 for exactly one cycle, mask ← 0.
  - If a commit lands on the same edge as the mask clear, the mask is loaded with only that commit's bit, so no capture is lost.
- Latency:
  - Input held steady before edge e1 is sampled on e1..eSTABLE.
  - Shadow write on eSTABLE+1.
  - frame_valid is high in the cycle after eSTABLE+2 when that commit completes the frame.
- Errors:
  - seg_err stays set until clr_err.
  - If clr_err and a new error occur on the same edge, the error wins (stays 1).
  - err_digit holds its value when cleared.
- Glitches: any change shorter than STABLE samples is ignored, including a segment change within a digit slot and a dig_sel change with seg_in unchanged.
- digits_out never shows a partial frame.

Test Plan:
1. Reset, then idle with dig_sel=0000 for 20 cycles → digits_out=16'hFFFF, frame_valid never asserts, seg_err=0.
2. DIGITS=4, STABLE=3; scan digits 0..3 with patterns 1111110, 0110000, 1101101, 1111001, 4 cycles each → one frame_valid pulse, 2 cycles after digit 3 commits; digits_out=16'h3210.
3. Repeat the scan of scenario 2 with a 2-cycle glitch of 1111111 inside digit 1's slot → glitch ignored; digits_out=16'h3210, seg_err=0.
4. Digit 2 shows 1000001 for 4 cycles, the others are legal → digits_out[11:8]=4'hE, seg_err=1, err_digit=2. Pulse clr_err → seg_err=0. Set clr_err in the same cycle as a new error → seg_err stays 1.
5. Hold dig_sel=0011 for 10 cycles, then do a legal full scan → no commit during 0011; a single frame_valid for the legal scan.
6. Assert rst after digits 0 and 1 commit, then scan 7, 8, 9, blank → no frame from the pre-reset data; outputs at reset values during rst; after the scan, digits_out=16'hF987.
